// File: rtl/skew_feeder.sv
// Tile buffer and parallelogram skew generator feeding one operand edge of a
// systolic matrix-multiply array: rows load into storage, then stream out with lane k delayed k steps.
module skew_feeder #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [DIM-1:0][BITS_AB-1:0]      Bin,
  input  logic                             start,
  input  logic                             en,
  output logic [DIM-1:0][BITS_AB-1:0]      Bout,
  output logic                             full,
  output logic                             busy,
  output logic                             done,
  output logic                             state_dbg
);

  localparam int TW    = $clog2(DEPTH + DIM);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST  = DEPTH + DIM - 2;
  localparam int DRAIN = DEPTH + DIM - 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                         state;
  logic [CW-1:0]                  cnt;
  logic [TW-1:0]                  t;
  logic [DIM-1:0][BITS_AB-1:0]    mem [DEPTH];
  logic [DIM-1:0][BITS_AB-1:0]    skew_row;
  logic                           write_en;

  // Handshake: load writes a row only while idle and not full; start is
  // accepted only while idle and full; en gates each stream step.
  assign write_en = (state == IDLE) && load && (cnt < CW'(DEPTH));

  // Storage is never reset; it is unreachable until a full tile is reloaded.
  always_ff @(posedge clk) begin
    if (write_en) mem[RW'(cnt)] <= Bin;
  end

  always_comb begin
    skew_row = '0;
    for (int k = 0; k < DIM; k++) begin
      if (int'(t) >= k && int'(t) < k + DEPTH)
        skew_row[k] = mem[RW'(int'(t) - k)][k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      t     <= '0;
      Bout  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          Bout <= '0;
          if (write_en) cnt <= cnt + CW'(1);
          if (start && cnt == CW'(DEPTH)) begin
            state <= STREAM;
            t     <= '0;
          end
        end
        STREAM: begin
          // t==DRAIN is the done cycle: the last step is on Bout, retire next edge.
          if (t == TW'(DRAIN)) begin
            state <= IDLE;
            cnt   <= '0;
            t     <= '0;
            Bout  <= '0;
          end else if (en) begin
            Bout <= skew_row;
            t    <= t + TW'(1);
            if (t == TW'(LAST)) done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full      = (state == IDLE) && (cnt == CW'(DEPTH));
  assign busy      = (state == STREAM);
  assign state_dbg = (state == STREAM);

endmodule
